// File: rtl/pingpong_wr_ctrl_pkg.sv
// Shared types and constants for the ping-pong buffer write controller.
package pingpong_wr_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DRAIN_WAIT,
        ANNOUNCE,
        COMMIT
    } state_t;

    localparam logic BANK1 = 1'b0;
    localparam logic BANK2 = 1'b1;

    localparam int DROP_CNT_W = 16;

endpackage

// File: rtl/pingpong_wr_ctrl_drop_counter.sv
// Saturating dropped-sample counter; clear has priority over increment.
module drop_counter
    import pingpong_wr_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc,
    input  logic                  clr,
    output logic [DROP_CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + DROP_CNT_W'(1);
        end
    end

endmodule

// File: rtl/pingpong_wr_ctrl.sv
// Write-side controller for the ping-pong buffer pair: steers samples into the
// active bank, swaps once the opposite bank is drained. Optional macro: DROP_CNT_EN.
module pingpong_wr_ctrl
    import pingpong_wr_ctrl_pkg::*;
#(
    parameter int DW        = 8,
    parameter int FRAME_LEN = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ENABLE,
    input  logic                  S_VALID,
    input  logic [DW-1:0]         S_DATA,
    input  logic                  FULL1,
    input  logic                  FULL2,
    input  logic                  EMPTY1,
    input  logic                  EMPTY2,
    output logic                  WR1,
    output logic                  WR2,
    output logic [DW-1:0]         WDATA,
    output logic                  W_FLAG,
    output logic                  DAQ,
    output logic                  COMPLE,
    output logic                  DROP,
    output logic [DROP_CNT_W-1:0] DROP_CNT
);

    localparam int             CW   = $clog2(FRAME_LEN);
    localparam logic [CW-1:0]  LAST = CW'(FRAME_LEN - 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          wfull;
    logic          rempty;
    logic          accepting;
    logic          write;
    logic          drop;

    // The write bank's full flag gates writes; the other bank's empty flag gates the swap.
    always_comb begin
        wfull     = W_FLAG ? FULL2 : FULL1;
        rempty    = W_FLAG ? EMPTY1 : EMPTY2;
        accepting = (state == FILL) || (state == ANNOUNCE) || (state == COMMIT);
        write     = accepting && S_VALID && !wfull;
        drop      = S_VALID && ((state == DRAIN_WAIT) || (accepting && wfull));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            W_FLAG <= BANK1;
            WR1    <= 1'b0;
            WR2    <= 1'b0;
            WDATA  <= '0;
            DAQ    <= 1'b0;
            COMPLE <= 1'b0;
            DROP   <= 1'b0;
        end else begin
            WR1    <= write && (W_FLAG == BANK1);
            WR2    <= write && (W_FLAG == BANK2);
            DROP   <= drop;
            DAQ    <= 1'b0;
            COMPLE <= 1'b0;
            if (write) begin
                WDATA <= S_DATA;
            end
            // The count holds at LAST once a frame is full until the swap clears it.
            if (write && (cnt != LAST)) begin
                cnt <= cnt + CW'(1);
            end
            case (state)
                IDLE: begin
                    if (ENABLE) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (write && (cnt == LAST)) begin
                        state <= DRAIN_WAIT;
                    end else if (!ENABLE && !write) begin
                        state <= (cnt != '0) ? DRAIN_WAIT : IDLE;
                    end
                end
                DRAIN_WAIT: begin
                    if (rempty) begin
                        W_FLAG <= ~W_FLAG;
                        cnt    <= '0;
                        DAQ    <= 1'b1;
                        state  <= ANNOUNCE;
                    end
                end
                ANNOUNCE: begin
                    COMPLE <= 1'b1;
                    state  <= COMMIT;
                end
                COMMIT: begin
                    if (write && (cnt == LAST)) begin
                        state <= DRAIN_WAIT;
                    end else if (ENABLE) begin
                        state <= FILL;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DROP_CNT_EN
    logic enable_q;
    logic drop_clr;

    // Remember ENABLE so a fresh acquisition start from IDLE clears the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            enable_q <= 1'b0;
        end else begin
            enable_q <= ENABLE;
        end
    end

    assign drop_clr = (state == IDLE) && ENABLE && !enable_q;

    drop_counter u_drop_counter (
        .clk   (clk),
        .rst   (rst),
        .inc   (drop),
        .clr   (drop_clr),
        .count (DROP_CNT)
    );
`else
    assign DROP_CNT = '0;
`endif

endmodule

// File: tb/tb_pingpong_wr_ctrl.sv
// Self-checking bench for pingpong_wr_ctrl: vector table, directed corner sequences,
// and randomized traffic checked against a frame-level reference model.
module tb_pingpong_wr_ctrl;

    localparam int   DW        = 8;
    localparam int   FRAME_LEN = 4;
    localparam logic H         = 1'b1;
    localparam logic L         = 1'b0;

    logic          clk = 1'b0;
    logic          rst;
    logic          ENABLE;
    logic          S_VALID;
    logic [DW-1:0] S_DATA;
    logic          FULL1;
    logic          FULL2;
    logic          EMPTY1;
    logic          EMPTY2;
    logic          WR1;
    logic          WR2;
    logic [DW-1:0] WDATA;
    logic          W_FLAG;
    logic          DAQ;
    logic          COMPLE;
    logic          DROP;
    logic [15:0]   DROP_CNT;

    pingpong_wr_ctrl #(.DW(DW), .FRAME_LEN(FRAME_LEN)) dut (
        .clk      (clk),
        .rst      (rst),
        .ENABLE   (ENABLE),
        .S_VALID  (S_VALID),
        .S_DATA   (S_DATA),
        .FULL1    (FULL1),
        .FULL2    (FULL2),
        .EMPTY1   (EMPTY1),
        .EMPTY2   (EMPTY2),
        .WR1      (WR1),
        .WR2      (WR2),
        .WDATA    (WDATA),
        .W_FLAG   (W_FLAG),
        .DAQ      (DAQ),
        .COMPLE   (COMPLE),
        .DROP     (DROP),
        .DROP_CNT (DROP_CNT)
    );

    always #5 clk = ~clk;

    int checksTotal  = 0;
    int checksPassed = 0;

    // Reference model: frame-level bookkeeping of the controller's behaviour.
    bit          mFilling;
    bit          mDraining;
    int          mPhase;
    int          mCount;
    int          mDrops;
    bit          mBank;
    bit          mPrevEn;
    logic        expWr1;
    logic        expWr2;
    logic        expDaq;
    logic        expComple;
    logic        expDrop;
    logic [7:0]  expWdata;

    typedef struct {
        logic       en;
        logic       v;
        logic [7:0] d;
        logic       f1;
        logic       f2;
        logic       e1;
        logic       e2;
        logic       wr1;
        logic       wr2;
        logic [7:0] wdata;
        logic       wflag;
        logic       daq;
        logic       comple;
        logic       drop;
    } vec_t;

    vec_t vectors [8];

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    endtask

    task automatic checkWord(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checksTotal++;
        if (actual === expected) checksPassed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    function automatic logic [15:0] expDropCnt();
`ifdef DROP_CNT_EN
        return mDrops[15:0];
`else
        return 16'd0;
`endif
    endfunction

    task automatic modelReset();
        mFilling  = 1'b0;
        mDraining = 1'b0;
        mPhase    = 0;
        mCount    = 0;
        mDrops    = 0;
        mBank     = 1'b0;
        mPrevEn   = 1'b0;
        expWr1    = 1'b0;
        expWr2    = 1'b0;
        expDaq    = 1'b0;
        expComple = 1'b0;
        expDrop   = 1'b0;
        expWdata  = 8'h00;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        bit idle;
        bit accepting;
        bit wfull;
        bit rempty;
        bit wr;
        bit dr;
        idle      = !mFilling && !mDraining && (mPhase == 0);
        accepting = mFilling || (mPhase != 0);
        wfull     = mBank ? FULL2 : FULL1;
        rempty    = mBank ? EMPTY1 : EMPTY2;
        wr        = accepting && S_VALID && !wfull;
        dr        = S_VALID && (mDraining || (accepting && wfull));
        expWr1    = wr && !mBank;
        expWr2    = wr && mBank;
        if (wr) expWdata = S_DATA;
        expDrop   = dr;
        expDaq    = mDraining && rempty;
        expComple = (mPhase == 1);
        if (dr && mDrops < 65535) mDrops++;
        if (wr) mCount++;
        if (idle) begin
            if (ENABLE && !mPrevEn) mDrops = 0;
            if (ENABLE) mFilling = 1'b1;
        end else if (mDraining) begin
            if (rempty) begin
                mDraining = 1'b0;
                mBank     = !mBank;
                mCount    = 0;
                mPhase    = 1;
            end
        end else if (mPhase == 1) begin
            mPhase = 2;
        end else if (mPhase == 2) begin
            mPhase = 0;
            if (mCount == FRAME_LEN) mDraining = 1'b1;
            else mFilling = ENABLE;
        end else begin
            if (mCount == FRAME_LEN) begin
                mFilling  = 1'b0;
                mDraining = 1'b1;
            end else if (!wr && !ENABLE) begin
                mFilling  = 1'b0;
                mDraining = (mCount > 0);
            end
        end
        mPrevEn = ENABLE;
    endtask

    task automatic checkOutput(input string tag);
        checkBit({tag, " WR1"}, WR1, expWr1);
        checkBit({tag, " WR2"}, WR2, expWr2);
        checkWord({tag, " WDATA"}, 16'(WDATA), 16'(expWdata));
        checkBit({tag, " W_FLAG"}, W_FLAG, mBank);
        checkBit({tag, " DAQ"}, DAQ, expDaq);
        checkBit({tag, " COMPLE"}, COMPLE, expComple);
        checkBit({tag, " DROP"}, DROP, expDrop);
        checkWord({tag, " DROP_CNT"}, DROP_CNT, expDropCnt());
        checkBit({tag, " WR exclusive"}, WR1 && WR2, 1'b0);
    endtask

    // Drive one cycle of inputs at the falling edge, clock it, check at the next falling edge.
    task automatic applyStimulus(input logic en, input logic v, input logic [7:0] d,
                                 input logic f1, input logic f2, input logic e1, input logic e2,
                                 input string tag);
        ENABLE  = en;
        S_VALID = v;
        S_DATA  = d;
        FULL1   = f1;
        FULL2   = f2;
        EMPTY1  = e1;
        EMPTY2  = e2;
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        int dropSeen;
        rst     = 1'b1;
        ENABLE  = 1'b0;
        S_VALID = 1'b0;
        S_DATA  = 8'h00;
        FULL1   = 1'b0;
        FULL2   = 1'b0;
        EMPTY1  = 1'b0;
        EMPTY2  = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        checkOutput("reset");
        rst = 1'b0;

        // First frame into buffer 1, then swap with DAQ/COMPLE.
        vectors[0] = '{H, L, 8'h00, L, L, L, H,  L, L, 8'h00, L, L, L, L};
        vectors[1] = '{H, H, 8'h11, L, L, L, H,  H, L, 8'h11, L, L, L, L};
        vectors[2] = '{H, H, 8'h12, L, L, L, H,  H, L, 8'h12, L, L, L, L};
        vectors[3] = '{H, H, 8'h13, L, L, L, H,  H, L, 8'h13, L, L, L, L};
        vectors[4] = '{H, H, 8'h14, L, L, L, H,  H, L, 8'h14, L, L, L, L};
        vectors[5] = '{H, L, 8'h00, L, L, L, H,  L, L, 8'h14, H, H, L, L};
        vectors[6] = '{H, L, 8'h00, L, L, L, H,  L, L, 8'h14, H, L, H, L};
        vectors[7] = '{H, L, 8'h00, L, L, L, H,  L, L, 8'h14, H, L, L, L};
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vectors[i].en, vectors[i].v, vectors[i].d, vectors[i].f1,
                          vectors[i].f2, vectors[i].e1, vectors[i].e2, $sformatf("vec%0d", i));
            checkBit($sformatf("vec%0d tbl WR1", i), WR1, vectors[i].wr1);
            checkBit($sformatf("vec%0d tbl WR2", i), WR2, vectors[i].wr2);
            checkWord($sformatf("vec%0d tbl WDATA", i), 16'(WDATA), 16'(vectors[i].wdata));
            checkBit($sformatf("vec%0d tbl W_FLAG", i), W_FLAG, vectors[i].wflag);
            checkBit($sformatf("vec%0d tbl DAQ", i), DAQ, vectors[i].daq);
            checkBit($sformatf("vec%0d tbl COMPLE", i), COMPLE, vectors[i].comple);
            checkBit($sformatf("vec%0d tbl DROP", i), DROP, vectors[i].drop);
        end

        // Second frame into buffer 2, drops while buffer 1 is still being drained.
        for (int k = 0; k < 4; k++)
            applyStimulus(H, H, 8'h21 + 8'(k), L, L, L, L, "seq2 fill");
        checkBit("seq2 last WR2", WR2, 1'b1);
        dropSeen = 0;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(H, H, 8'hA0 + 8'(k), L, L, L, L, "seq2 wait");
            if (DROP) dropSeen++;
        end
        checkWord("seq2 drop pulses", 16'(dropSeen), 16'd3);
`ifdef DROP_CNT_EN
        checkWord("seq2 DROP_CNT", DROP_CNT, 16'd3);
`endif
        applyStimulus(H, L, 8'h00, L, L, H, L, "seq2 swap");
        checkBit("seq2 swap DAQ", DAQ, 1'b1);
        checkBit("seq2 swap W_FLAG", W_FLAG, 1'b0);
        applyStimulus(H, L, 8'h00, L, L, H, L, "seq2 commit");
        checkBit("seq2 COMPLE", COMPLE, 1'b1);
        applyStimulus(H, L, 8'h00, L, L, L, L, "seq2 refill");

        // Buffer 1 full: samples dropped, then writes resume.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(H, H, 8'h30 + 8'(k), H, L, L, L, "seq3 full");
            checkBit("seq3 full WR1", WR1, 1'b0);
            checkBit("seq3 full DROP", DROP, 1'b1);
        end
        for (int k = 0; k < 2; k++) begin
            applyStimulus(H, H, 8'h31 + 8'(k), L, L, L, L, "seq3 resume");
            checkBit("seq3 resume WR1", WR1, 1'b1);
        end

        // Partial frame flush on ENABLE falling, then samples in IDLE are ignored.
        applyStimulus(L, L, 8'h00, L, L, L, H, "seq4 flush");
        applyStimulus(L, L, 8'h00, L, L, L, H, "seq4 swap");
        checkBit("seq4 swap DAQ", DAQ, 1'b1);
        checkBit("seq4 swap W_FLAG", W_FLAG, 1'b1);
        applyStimulus(L, L, 8'h00, L, L, L, H, "seq4 commit");
        applyStimulus(L, L, 8'h00, L, L, L, H, "seq4 idle");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(L, H, 8'h70 + 8'(k), L, L, L, L, "seq4 ignored");
            checkBit("seq4 idle WR2", WR2, 1'b0);
            checkBit("seq4 idle DROP", DROP, 1'b0);
        end

        // Last sample coincident with ENABLE falling: full frame, COMMIT returns to IDLE.
        applyStimulus(H, L, 8'h00, L, L, L, L, "seq5 start");
        for (int k = 0; k < 3; k++)
            applyStimulus(H, H, 8'h41 + 8'(k), L, L, L, L, "seq5 fill");
        applyStimulus(L, H, 8'h44, L, L, L, L, "seq5 last");
        checkBit("seq5 last WR2", WR2, 1'b1);
        checkWord("seq5 last WDATA", 16'(WDATA), 16'h0044);
        applyStimulus(L, L, 8'h00, L, L, H, L, "seq5 swap");
        checkBit("seq5 swap DAQ", DAQ, 1'b1);
        applyStimulus(L, L, 8'h00, L, L, H, L, "seq5 commit");
        applyStimulus(L, L, 8'h00, L, L, H, L, "seq5 idle");
        applyStimulus(L, H, 8'h45, L, L, H, L, "seq5 ignored");
        checkBit("seq5 idle WR1", WR1, 1'b0);

        // Reset asserted mid-ANNOUNCE clears every pulse and the bank select at once.
        applyStimulus(H, L, 8'h00, L, L, L, H, "seq6 start");
        for (int k = 0; k < 4; k++)
            applyStimulus(H, H, 8'h51 + 8'(k), L, L, L, H, "seq6 fill");
        applyStimulus(H, L, 8'h00, L, L, L, H, "seq6 swap");
        checkBit("seq6 pre-reset DAQ", DAQ, 1'b1);
        #2 rst = 1'b1;
        #1;
        checkBit("seq6 rst DAQ", DAQ, 1'b0);
        checkBit("seq6 rst COMPLE", COMPLE, 1'b0);
        checkBit("seq6 rst W_FLAG", W_FLAG, 1'b0);
        checkBit("seq6 rst WR1", WR1, 1'b0);
        checkBit("seq6 rst WR2", WR2, 1'b0);
        checkBit("seq6 rst DROP", DROP, 1'b0);
        checkWord("seq6 rst DROP_CNT", DROP_CNT, 16'd0);
        modelReset();
        ENABLE  = 1'b0;
        S_VALID = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(H, H, 8'h61, L, L, L, L, "seq6 enable");
        applyStimulus(H, H, 8'h62, L, L, L, L, "seq6 first");
        checkBit("seq6 first WR1", WR1, 1'b1);
        checkBit("seq6 first WR2", WR2, 1'b0);
        checkWord("seq6 first WDATA", 16'(WDATA), 16'h0062);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 800; n++) begin
            applyStimulus(logic'($urandom_range(0, 15) != 0),
                          logic'($urandom_range(0, 3) != 0),
                          8'($urandom),
                          logic'($urandom_range(0, 7) == 0),
                          logic'($urandom_range(0, 7) == 0),
                          logic'($urandom_range(0, 1) == 1),
                          logic'($urandom_range(0, 1) == 1),
                          $sformatf("rand%0d", n));
        end

        $display("%0d/%0d checks passed", checksPassed, checksTotal);
        $finish;
    end

endmodule

// File: doc/pingpong_wr_ctrl.md
# pingpong_wr_ctrl

Write-side controller for the science ping-pong buffer pair: accepts acquisition samples, steers them into buffer 1 or buffer 2, and counts frame length. It swaps banks only once the sender has drained the opposite bank. On each swap it issues the DAQ/COMPLE notification pair that starts the send controller. It sits between the acquisition front end and the two buffer FIFOs. It drives W_FLAG, from which the sender derives its read-bank select (SEL = ~W_FLAG).

## Interface
- DW, 8, sample/word width
- FRAME_LEN, 256, samples per full frame (≥2)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- ENABLE  in  1  acquisition enable (level)
- S_VALID  in  1  sample strobe, one word per cycle
- S_DATA  in  DW  sample word
- FULL1, FULL2  in  1  buffer full flags
- EMPTY1, EMPTY2  in  1  buffer empty flags
- WR1, WR2  out  1  buffer write enables
- WDATA  out  DW  buffer write data
- W_FLAG  out  1  write bank: 0 = buffer 1, 1 = buffer 2
- DAQ  out  1  one-cycle "frame ready" pulse to sender
- COMPLE  out  1  one-cycle "frame committed" pulse, one cycle after DAQ
- DROP  out  1  one-cycle pulse per discarded sample
- DROP_CNT  out  16  dropped-sample count (see Configuration)

## Operation
- Signal mapping:
  - Write bank is selected by W_FLAG.
  - wfull = W_FLAG ? FULL2 : FULL1.
  - rempty = W_FLAG ? EMPTY1 : EMPTY2.
- States:
  - IDLE: ENABLE=1 → FILL.
  - FILL:
    - S_VALID & !wfull writes the sample and increments cnt.
    - A write with cnt==FRAME_LEN-1 → DRAIN_WAIT.
    - ENABLE=0 with cnt>0 and no write this cycle → DRAIN_WAIT (partial frame flush).
    - ENABLE=0 with cnt==0 → IDLE.
  - DRAIN_WAIT:
    - rempty=1 → toggle W_FLAG, clear cnt, → ANNOUNCE.
    - Otherwise hold.
  - ANNOUNCE: DAQ=1, → COMMIT.
  - COMMIT: COMPLE=1, → FILL if ENABLE, else IDLE.
- Sample acceptance:
  - Samples in ANNOUNCE and COMMIT are written into the new bank and counted.
  - Samples in IDLE are ignored, with no DROP pulse.
  - Samples in DRAIN_WAIT are dropped, with a DROP pulse.
  - S_VALID with wfull=1 in FILL/ANNOUNCE/COMMIT is dropped, with a DROP pulse; cnt is unchanged.
- Simultaneous events:
  - Last sample plus ENABLE=0 in the same cycle: the sample is written and the frame completes normally; COMMIT then goes to IDLE.
  - rempty rising in the same cycle the frame completes: the swap happens in the following cycle (DRAIN_WAIT is always entered for at least one cycle).
- cnt is CW = $clog2(FRAME_LEN) bits and never exceeds FRAME_LEN-1.
- Reset mid-operation:
  - State goes to IDLE, cnt=0, W_FLAG=0.
  - All pulses deassert immediately.
  - Buffer contents are not touched.

## Timing
- All outputs are registered.
- Reset values: WR1=WR2=0, WDATA=0, W_FLAG=0, DAQ=COMPLE=DROP=0, DROP_CNT=0.
- Write latency: S_VALID sampled at edge n → WRx and WDATA valid for exactly cycle n+1.
- Swap: rempty seen at edge n → W_FLAG toggles at n+1, DAQ high cycle n+1, COMPLE high cycle n+2.
- DAQ and COMPLE are each exactly one cycle wide and never overlap.
- WR1 and WR2 are never high together.

## Configuration
- Macro: DROP_CNT_EN.
- Defined:
  - DROP_CNT is a 16-bit saturating counter (holds at 0xFFFF), incremented on each DROP.
  - It clears on the ENABLE 0→1 transition observed in IDLE.
- Undefined: DROP_CNT is tied to 0 and no counter logic is instantiated. DROP is still generated.

## Structure
- Shared package holds:
  - the state enum (IDLE, FILL, DRAIN_WAIT, ANNOUNCE, COMMIT);
  - the bank encoding constants (BANK1=0, BANK2=1);
  - the DROP_CNT width (16).
- Sub-module: drop_counter (saturating 16-bit counter with inc/clear). It is instantiated only under DROP_CNT_EN.

## Test plan
- FRAME_LEN=4, EMPTY2=1, ENABLE=1, samples 0x11..0x14 → four WR1 pulses carrying 0x11..0x14; W_FLAG 0→1; DAQ pulse, then COMPLE pulse on the next cycle.
- Second frame 0x21..0x24 with EMPTY1=0 → WR2 writes, then DRAIN_WAIT. Three samples in the wait → 3 DROP pulses, DROP_CNT=3. Raise EMPTY1 → W_FLAG→0, then DAQ and COMPLE.
- FULL1=1 during FILL with two samples → no WR1, 2 DROP pulses, cnt unchanged. FULL1=0 → writes resume at the same cnt.
- After 2 samples, drop ENABLE → partial-frame swap (W_FLAG toggles, DAQ/COMPLE) → IDLE. Further samples in IDLE → no WR, no DROP.
- Fourth sample coincident with ENABLE falling → sample written, normal swap, COMMIT→IDLE.
- Assert rst during ANNOUNCE → DAQ, COMPLE, WRx and W_FLAG all 0 immediately. After release, the first sample goes to buffer 1.
